// File: rtl/rmw_counter_bank.sv
// Read-modify-write counter bank: each accepted request adds a delta to one entry
// and returns the new value. Optional saturation build macro: RMW_COUNTER_SATURATE_EN.
module rmw_counter_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned INC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [ADDR_W-1:0] io_in_addr,
  input  logic [INC_W-1:0]  io_in_delta,
  input  logic              io_clear,
  output logic              io_busy,
  output logic              io_out_valid,
  output logic [DATA_W-1:0] io_out_data,
  input  logic [ADDR_W-1:0] io_rd_addr,
  output logic [DATA_W-1:0] io_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [INC_W-1:0]  s1_delta;
  logic [DATA_W-1:0] rd_q;
  logic              byp_valid;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign io_in_ready = (state == ST_IDLE) && !io_clear;
  assign io_busy     = (state == ST_CLEAR);
  assign accept      = io_in_valid && io_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next-state logic: clear sweep walks every entry once, then returns to idle
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == ST_IDLE) begin
      if (io_clear) begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    end else begin
      clr_ptr_nxt = clr_ptr + ADDR_W'(1);
      if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // Stage-1 adder; bypass covers the entry written on the same edge as our read
  always_comb begin
    base = byp_valid ? byp_data : rd_q;
`ifdef RMW_COUNTER_SATURATE_EN
    begin
      logic [SUM_W-1:0] sum_wide;
      sum_wide = {1'b0, base} + SUM_W'(s1_delta);
      sum      = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
    end
`else
    sum = base + DATA_W'(s1_delta);
`endif
  end

  // Single write port shared by the sweep and the pipeline; they never overlap
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_addr;
    mem_wdata = sum;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else if (s1_valid) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_q       <= mem[io_in_addr];
    io_rd_data <= mem[io_rd_addr];
  end

  // Pipeline control; reset drops any op sitting in stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      byp_valid    <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
    end else begin
      s1_valid     <= accept;
      byp_valid    <= s1_valid && accept && (io_in_addr == s1_addr);
      io_out_valid <= s1_valid;
      if (s1_valid) begin
        io_out_data <= sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    byp_data <= sum;
    if (accept) begin
      s1_addr  <= io_in_addr;
      s1_delta <= io_in_delta;
    end
  end

endmodule
